// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg
//   Shared definitions for the data-memory access controller: FSM state
//   encoding, default bus-timeout budget and default error read data.
//   Imported by the controller and available to CPU-level benches.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEF_ERR_RDATA      = 32'h0000_0000;

  // All byte enables clear means the access is a load.
  function automatic logic is_load(input logic [3:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sits between the single-cycle CPU data port and a variable-latency memory
//   with a valid/ready request channel and a response channel. Each load/store
//   is captured, issued to memory, and the CPU is held on cpu_stall until the
//   response (or write ack) arrives. A per-access timeout aborts hung accesses
//   and raises a sticky bus_err.
//
//   Ports
//     clk, reset                 clock (rising edge), async active-high reset
//     cpu_req/cpu_daddr/
//     cpu_dwdata/cpu_we          CPU access request; cpu_we == 0 means load
//     cpu_drdata                 load data returned to the CPU
//     cpu_stall                  CPU external stall
//     mem_req_valid/mem_req_ready/
//     mem_addr/mem_wdata/mem_we  memory request channel (held until accepted)
//     mem_rsp_valid/mem_rdata    memory response / write ack
//     bus_err                    sticky timeout flag, cleared only by reset
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_daddr,
  input  logic [31:0] cpu_dwdata,
  input  logic [3:0]  cpu_we,
  output logic [31:0] cpu_drdata,
  output logic        cpu_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against the last permitted cycle so the abort takes effect on
  // exactly the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e      state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_hit;

  assign timeout_hit = (tmo_cnt == CNT_LAST);

  assign cpu_stall = ((state == ST_IDLE) && cpu_req) ||
                     (state == ST_REQ) || (state == ST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= '0;
      cpu_drdata    <= '0;
      bus_err       <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            mem_addr      <= cpu_daddr;
            mem_wdata     <= cpu_dwdata;
            mem_we        <= cpu_we;
            mem_req_valid <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Counter saturates at TIMEOUT_CYCLES because we leave REQ/WAIT on
          // the same edge it gets there.
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (timeout_hit) begin
            mem_req_valid <= 1'b0;
            bus_err       <= 1'b1;
            if (is_load(mem_we)) cpu_drdata <= ERR_RDATA;
            state         <= ST_DONE;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          // A response on the expiry cycle completes normally.
          if (mem_rsp_valid) begin
            if (is_load(mem_we)) cpu_drdata <= mem_rdata;
            state <= ST_DONE;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            if (is_load(mem_we)) cpu_drdata <= ERR_RDATA;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
